skid_fifo: RTL and testbench

SKID_FIFO -- requirements
Module: skid_fifo

---
 rtl/skid_fifo.sv | 98 +++++++++
 tb/tb_skid_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/skid_fifo.sv
// Skid FIFO: DEPTH-entry circular buffer with optional empty-buffer pass-through.
// Latency: 0 cycles when BYPASS=1 and the buffer is empty, otherwise 1+ cycles.
// Backpressure: registered_busy_o is a flop that asserts once the buffer is full.
module skid_fifo #(
  parameter int DW     = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       combinational_busy_i,
  output logic [DW-1:0]              cycle_data_o,
  output logic                       cycle_vld_o,
  output logic                       registered_busy_o,
  input  logic [DW-1:0]              registered_data_i,
  input  logic                       registered_vld_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam bit BYP = (BYPASS != 0);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_next;
  logic          busy_q;

  logic empty;
  logic in_acc;
  logic out_acc;
  logic bypass_take;
  logic push;
  logic pop;

  assign empty   = (count_q == '0);
  assign in_acc  = registered_vld_i & ~busy_q;
  assign out_acc = cycle_vld_o & ~combinational_busy_i;

  // A beat consumed straight through the bypass path never touches storage.
  assign bypass_take = BYP & empty & out_acc;
  assign push        = in_acc & ~bypass_take;
  assign pop         = out_acc & ~empty;

  // Head of line: storage when non-empty, else upstream (bypass) or nothing.
  always_comb begin
    cycle_vld_o  = 1'b0;
    cycle_data_o = mem_q[rd_ptr_q];
    if (!empty) begin
      cycle_vld_o = 1'b1;
    end else if (BYP) begin
      cycle_vld_o  = registered_vld_i;
      cycle_data_o = registered_data_i;
    end
  end

  // Next occupancy from the push/pop pair; simultaneous push and pop cancel.
  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Pointers, count and the upstream busy flop; all cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      count_q <= count_next;
      busy_q  <= (count_next == CW'(DEPTH));
    end
  end

  // Payload storage; contents are don't-care after reset since count gates reads.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= registered_data_i;
    end
  end

  assign registered_busy_o = busy_q;
  assign occupancy_o       = count_q;

endmodule

// File: tb/tb_skid_fifo.sv
module tb_skid_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // BYPASS=1 instance
  logic       b1_busy, b1_vld, b1_ovld, b1_rbusy;
  logic [7:0] b1_din, b1_dout;
  logic [2:0] b1_occ;

  // BYPASS=0 instance
  logic       b0_busy, b0_vld, b0_ovld, b0_rbusy;
  logic [7:0] b0_din, b0_dout;
  logic [2:0] b0_occ;

  skid_fifo #(.DW(8), .DEPTH(4), .BYPASS(1)) u_byp (
    .clk_i                (clk),
    .reset_ni             (rst_n),
    .combinational_busy_i (b1_busy),
    .cycle_data_o         (b1_dout),
    .cycle_vld_o          (b1_ovld),
    .registered_busy_o    (b1_rbusy),
    .registered_data_i    (b1_din),
    .registered_vld_i     (b1_vld),
    .occupancy_o          (b1_occ)
  );

  skid_fifo #(.DW(8), .DEPTH(4), .BYPASS(0)) u_reg (
    .clk_i                (clk),
    .reset_ni             (rst_n),
    .combinational_busy_i (b0_busy),
    .cycle_data_o         (b0_dout),
    .cycle_vld_o          (b0_ovld),
    .registered_busy_o    (b0_rbusy),
    .registered_data_i    (b0_din),
    .registered_vld_i     (b0_vld),
    .occupancy_o          (b0_occ)
  );

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       busy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] eo;
    logic       erb;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic vld, input logic [7:0] din, input logic busy,
                     input logic ev, input logic [7:0] ed, input logic [2:0] eo,
                     input logic erb);
    vec_t v;
    v.vld = vld; v.din = din; v.busy = busy;
    v.ev = ev; v.ed = ed; v.eo = eo; v.erb = erb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    rst_n   = 1'b0;
    b1_busy = 1'b0; b1_vld = 1'b0; b1_din = 8'h00;
    b0_busy = 1'b0; b0_vld = 1'b0; b0_din = 8'h00;

    // Table for the bypass instance: {vld, din, busy} -> {vld_o, data_o, occ, busy_o}
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // back-to-back pass-through
    add(1, 8'h11, 0, 1, 8'h11, 0, 0);
    add(1, 8'h22, 0, 1, 8'h22, 0, 0);
    add(1, 8'h33, 0, 1, 8'h33, 0, 0);
    // fill while downstream busy
    add(1, 8'hA0, 1, 1, 8'hA0, 0, 0);
    add(1, 8'hA1, 1, 1, 8'hA0, 1, 0);
    add(1, 8'hA2, 1, 1, 8'hA0, 2, 0);
    add(1, 8'hA3, 1, 1, 8'hA0, 3, 0);
    add(1, 8'hA4, 1, 1, 8'hA0, 4, 1);
    add(1, 8'hA4, 1, 1, 8'hA0, 4, 1);
    // one-cycle release from full, then A4 accepted and order kept
    add(1, 8'hA4, 0, 1, 8'hA0, 4, 1);
    add(1, 8'hA4, 1, 1, 8'hA1, 3, 0);
    add(0, 8'h00, 0, 1, 8'hA1, 4, 1);
    add(0, 8'h00, 0, 1, 8'hA2, 3, 0);
    add(0, 8'h00, 0, 1, 8'hA3, 2, 0);
    add(0, 8'h00, 0, 1, 8'hA4, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);
    // count=2 then 8 cycles of simultaneous push/pop across the wrap
    add(1, 8'hB0, 1, 1, 8'hB0, 0, 0);
    add(1, 8'hB1, 1, 1, 8'hB0, 1, 0);
    for (int k = 0; k < 8; k++)
      add(1, 8'hB2 + 8'(k), 0, 1, 8'hB0 + 8'(k), 2, 0);
    add(0, 8'h00, 0, 1, 8'hB8, 2, 0);
    add(0, 8'h00, 0, 1, 8'hB9, 1, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0, 0);

    // Reset state, including combinational valid pass-through during reset
    #1;
    chk("rst_occ", 32'(b1_occ), 32'd0);
    chk("rst_rbusy", 32'(b1_rbusy), 32'd0);
    chk("rst_reg_vld", 32'(b0_ovld), 32'd0);
    b1_vld = 1'b1; b0_vld = 1'b1;
    #1;
    chk("rst_byp_vld_follow", 32'(b1_ovld), 32'd1);
    chk("rst_reg_vld_hi_in", 32'(b0_ovld), 32'd0);
    b1_vld = 1'b0; b0_vld = 1'b0;
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      b1_vld = vecs[i].vld; b1_din = vecs[i].din; b1_busy = vecs[i].busy;
      #1;
      chk($sformatf("v%0d_vld", i), 32'(b1_ovld), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("v%0d_data", i), 32'(b1_dout), 32'(vecs[i].ed));
      chk($sformatf("v%0d_occ", i), 32'(b1_occ), 32'(vecs[i].eo));
      chk($sformatf("v%0d_rbusy", i), 32'(b1_rbusy), 32'(vecs[i].erb));
    end

    // Async reset with three beats stored: nothing stale after release
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b1_vld = 1'b1; b1_din = 8'hC0 + 8'(k); b1_busy = 1'b1;
    end
    @(negedge clk);
    b1_vld = 1'b0;
    #1 chk("pre_rst_occ", 32'(b1_occ), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_occ", 32'(b1_occ), 32'd0);
    chk("async_rst_rbusy", 32'(b1_rbusy), 32'd0);
    chk("async_rst_vld", 32'(b1_ovld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; b1_busy = 1'b0;
    #1 chk("post_rst_idle_vld", 32'(b1_ovld), 32'd0);
    @(negedge clk);
    b1_vld = 1'b1; b1_din = 8'hD0;
    #1;
    chk("post_rst_first_vld", 32'(b1_ovld), 32'd1);
    chk("post_rst_first_data", 32'(b1_dout), 32'hD0);
    chk("post_rst_first_occ", 32'(b1_occ), 32'd0);
    @(negedge clk);
    b1_vld = 1'b0;
    #1;
    chk("post_rst_no_stale_vld", 32'(b1_ovld), 32'd0);
    chk("post_rst_no_stale_occ", 32'(b1_occ), 32'd0);

    // Registered mode: single beat shows up one cycle later
    @(negedge clk);
    b0_vld = 1'b1; b0_din = 8'h5A; b0_busy = 1'b0;
    #1;
    chk("reg_t0_vld", 32'(b0_ovld), 32'd0);
    chk("reg_t0_occ", 32'(b0_occ), 32'd0);
    @(negedge clk);
    b0_vld = 1'b0;
    #1;
    chk("reg_t1_vld", 32'(b0_ovld), 32'd1);
    chk("reg_t1_data", 32'(b0_dout), 32'h5A);
    chk("reg_t1_occ", 32'(b0_occ), 32'd1);
    @(negedge clk);
    #1;
    chk("reg_t2_vld", 32'(b0_ovld), 32'd0);
    chk("reg_t2_occ", 32'(b0_occ), 32'd0);

    // Registered mode: two beats held under busy, drained in order
    @(negedge clk);
    b0_vld = 1'b1; b0_din = 8'hE1; b0_busy = 1'b1;
    #1 chk("reg_e_t0_vld", 32'(b0_ovld), 32'd0);
    @(negedge clk);
    b0_din = 8'hE2;
    #1;
    chk("reg_e_t1_data", 32'(b0_dout), 32'hE1);
    chk("reg_e_t1_occ", 32'(b0_occ), 32'd1);
    @(negedge clk);
    b0_vld = 1'b0; b0_busy = 1'b0;
    #1;
    chk("reg_e_t2_data", 32'(b0_dout), 32'hE1);
    chk("reg_e_t2_occ", 32'(b0_occ), 32'd2);
    @(negedge clk);
    #1;
    chk("reg_e_t3_data", 32'(b0_dout), 32'hE2);
    chk("reg_e_t3_occ", 32'(b0_occ), 32'd1);
    @(negedge clk);
    #1;
    chk("reg_e_t4_vld", 32'(b0_ovld), 32'd0);
    chk("reg_e_t4_rbusy", 32'(b0_rbusy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
